rr_arb8: RTL and testbench
==========================

RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 4, meaning the maximum consecutive cycles one grant is held while other requesters are waiting (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port req, input, 8 bits, per-requester request; bit i belongs to requester i.
REQ-005 SHALL have port d, input, 8 bits, per-requester 1-bit data; bit i belongs to requester i.
REQ-006 SHALL have port gnt, output, 8 bits, registered one-hot grant; all-zero when idle.
REQ-007 SHALL have port sel, output, 3 bits, registered binary index of the granted requester; drives the shared 8:1 select.
REQ-008 SHALL have port valid, output, 1 bit, registered; high exactly when gnt is nonzero.
REQ-009 SHALL have port y, output, 1 bit, shared data output; equals d[sel] combinationally when valid is high, else 0.

Function
REQ-010 SHALL implement two states, IDLE (no grant) and GRANT (one requester owns the output).
REQ-011 SHALL keep a 3-bit round-robin pointer ptr; a search starts at index ptr and ascends modulo 8, 7 wraps to 0; the first asserted req bit wins.
REQ-012 SHALL, on every new grant to index k, set ptr to (k+1) mod 8 in the same edge.
REQ-013 SHALL keep a 4-bit hold counter hcnt: set to 1 on a new grant, incremented on each held cycle, saturating at MAX_HOLD.
REQ-014 IDLE, req all zero: SHALL stay IDLE, outputs unchanged at their idle values.
REQ-015 IDLE, any req bit high at the edge: SHALL enter GRANT with gnt/sel/valid updated at that edge; latency from req to grant is 1 cycle.
REQ-016 GRANT, req[sel] low at the edge, other bits high: SHALL grant the next requester via search from ptr in the same edge; no idle gap.
REQ-017 GRANT, req all zero at the edge: SHALL return to IDLE; gnt=0, valid=0, sel retains its last value.
REQ-018 GRANT, req[sel] high, hcnt < MAX_HOLD: SHALL hold the grant and increment hcnt.
REQ-019 GRANT, req[sel] high, hcnt == MAX_HOLD, another req bit high: SHALL rotate to the search winner from ptr, excluding the current owner, with hcnt=1.
REQ-020 GRANT, req[sel] high, no other req bit high: SHALL hold indefinitely; hcnt stays at MAX_HOLD.
REQ-021 SHALL never assert more than one gnt bit; sel SHALL always equal the index of the set gnt bit when valid is high.
REQ-022 Requests that assert and deassert between edges SHALL be ignored; only values sampled at the rising edge matter.

Reset
REQ-023 rst high at an edge SHALL force IDLE, gnt=0, sel=0, valid=0, ptr=0, hcnt=0, regardless of req; it overrides all other transitions.
REQ-024 rst asserted mid-grant SHALL drop the grant at that edge; the first edge with rst low SHALL arbitrate from ptr=0.
REQ-025 y SHALL be 0 while in reset, because valid is 0.

Verification
REQ-026 Reset then req=8'b0000_0001 held, d[0]=1 -> one cycle later gnt=01, sel=0, valid=1, y=1; the grant is held indefinitely.
REQ-027 From reset, req=8'hFF held, MAX_HOLD=4 -> grants 0,1,2,...,7,0 in order, each held exactly 4 cycles, with no idle cycle between grants.
REQ-028 Owner 7 drops req while req[0] and req[3] are high, ptr=0 -> next edge gnt=8'h01 (wrap-around), valid stays 1.
REQ-029 Owner 2 holding, req=8'h04 only, for 10 cycles -> gnt stays 8'h04 for all 10 cycles; hcnt saturates at 4.
REQ-030 rst pulsed for one cycle while owner 5 holds and req=8'h28 -> gnt=0, valid=0, y=0 at that edge; the next edge grants 3 (search from ptr=0).
REQ-031 All req drop while granted -> next edge valid=0, gnt=0, y=0, sel unchanged; a single req[6] two cycles later -> gnt=8'h40 one cycle after.

Source files
------------

// File: rtl/rr_arb8.sv
// rr_arb8: eight-way round-robin arbiter with bounded hold time.
// One requester at a time owns the shared 1-bit data path. The owner keeps
// the grant while it requests, but must give it up after MAX_HOLD
// consecutive cycles if anyone else is waiting. The search for a new owner
// starts at a rotating pointer, which keeps arbitration fair.
module rr_arb8 #(
    parameter int MAX_HOLD = 4  // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] d,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       valid,
    output logic       y
);

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Result of one round-robin search.
    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    state_t     state, state_next;
    logic [7:0] gnt_next;
    logic [2:0] sel_next;
    logic       valid_next;
    logic [2:0] ptr, ptr_next;
    logic [3:0] hcnt, hcnt_next;

    pick_t any_pick;    // winner among all requesters
    pick_t other_pick;  // winner when the current owner is left out
    pick_t win;         // the requester that takes a new grant this edge
    logic  take;        // a new grant is issued this edge

    // Search upward from start, modulo 8. The first set bit wins. The loop
    // runs from the farthest offset down to the nearest, so the nearest
    // requester is written last and takes priority.
    function automatic pick_t rr_search(input logic [7:0] r, input logic [2:0] start);
        pick_t      p;
        logic [2:0] cand;
        p.found = 1'b0;
        p.idx   = start;
        for (int i = 7; i >= 0; i--) begin
            cand = start + 3'(i);
            if (r[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

    // Candidate winners from the registered pointer and the sampled requests.
    always_comb begin
        any_pick   = rr_search(req, ptr);
        // gnt is one-hot, so it also serves as the owner's mask.
        other_pick = rr_search(req & ~gnt, ptr);
    end

    // Next-state logic: decide to hold, rotate, re-grant, or go idle.
    always_comb begin
        // NOTE: every output of this block gets a default first. A path that
        // left a signal unassigned would make synthesis infer a latch.
        state_next = state;
        gnt_next   = gnt;
        sel_next   = sel;
        valid_next = valid;
        ptr_next   = ptr;
        hcnt_next  = hcnt;
        take       = 1'b0;
        win        = any_pick;

        unique case (state)
            IDLE: begin
                if (any_pick.found) begin
                    take = 1'b1;
                    win  = any_pick;
                end
            end

            GRANT: begin
                if (req == 8'h00) begin
                    // Everyone has gone quiet. sel keeps its last value.
                    state_next = IDLE;
                    gnt_next   = 8'h00;
                    valid_next = 1'b0;
                    hcnt_next  = 4'd0;
                end else if (!req[sel]) begin
                    // The owner released the grant and someone else is
                    // waiting. Hand over at once with no idle gap.
                    take = 1'b1;
                    win  = any_pick;
                end else if (hcnt < MAX_HOLD_C) begin
                    hcnt_next = hcnt + 4'd1;
                end else if (other_pick.found) begin
                    // The hold budget is spent and another requester is
                    // waiting, so the owner must yield.
                    take = 1'b1;
                    win  = other_pick;
                end
                // Otherwise the owner is alone. It keeps the grant and hcnt
                // stays saturated.
            end

            default: begin
                state_next = IDLE;
                gnt_next   = 8'h00;
                valid_next = 1'b0;
            end
        endcase

        if (take) begin
            state_next = GRANT;
            gnt_next   = 8'h01 << win.idx;
            sel_next   = win.idx;
            valid_next = 1'b1;
            ptr_next   = win.idx + 3'd1;
            hcnt_next  = 4'd1;
        end
    end

    // State and output registers. Reset is synchronous and takes priority
    // over all other updates.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. Every
        // register then samples the values from before the edge, regardless
        // of statement order.
        if (rst) begin
            state <= IDLE;
            gnt   <= 8'h00;
            sel   <= 3'd0;
            valid <= 1'b0;
            ptr   <= 3'd0;
            hcnt  <= 4'd0;
        end else begin
            state <= state_next;
            gnt   <= gnt_next;
            sel   <= sel_next;
            valid <= valid_next;
            ptr   <= ptr_next;
            hcnt  <= hcnt_next;
        end
    end

    // Shared 8:1 data mux. The output is forced low when nothing is granted.
    assign y = valid & d[sel];

endmodule

// File: tb/tb_rr_arb8.sv
// tb_rr_arb8: directed, self-checking bench for rr_arb8 with MAX_HOLD=4.
module tb_rr_arb8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] d;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       y;

    int total = 0;
    int bad   = 0;

    rr_arb8 #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .d     (d),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid),
        .y     (y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check all outputs against the expected grant index. A zero exp_gnt
    // means idle. In that case exp_sel is the retained select value.
    task automatic expect_out(input string tag, input logic [7:0] exp_gnt, input logic [2:0] exp_sel);
        logic exp_valid;
        exp_valid = (exp_gnt != 8'h00);
        check({tag, ".gnt"},   32'(gnt),   32'(exp_gnt));
        check({tag, ".sel"},   32'(sel),   32'(exp_sel));
        check({tag, ".valid"}, 32'(valid), 32'(exp_valid));
        check({tag, ".y"},     32'(y),     32'(exp_valid & d[exp_sel]));
    endtask

    initial begin
        rst = 1'b1;
        req = 8'hFF;
        d   = 8'h00;

        // Reset must win even while every requester is asking.
        tick();
        tick();
        expect_out("reset", 8'h00, 3'd0);

        // A single requester 0 is granted one cycle later and holds the
        // grant indefinitely.
        rst = 1'b0;
        req = 8'h01;
        d   = 8'h01;
        tick();
        expect_out("single0", 8'h01, 3'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("single0_hold", 32'(gnt), 32'h01);
        end
        d = 8'h00;
        #1;
        check("y_follows_d", 32'(y), 32'd0);

        // Full load from reset: owners 0..7, then 0 again. Each owner holds
        // for 4 cycles. The loop stops one cycle into owner 7's turn.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'hFF;
        d   = 8'hA5;
        for (int n = 0; n <= 28; n++) begin
            tick();
            check("rotate_sel", 32'(sel),   32'((n / 4) % 8));
            check("rotate_gnt", 32'(gnt),   32'(8'h01 << ((n / 4) % 8)));
            check("rotate_val", 32'(valid), 32'd1);
        end

        // Owner 7 drops its request while 0 and 3 are waiting (ptr=0).
        // The grant wraps around to 0.
        req = 8'h09;
        tick();
        expect_out("wrap7to0", 8'h01, 3'd0);

        // Owner 0 drops its request. The search from ptr=1 finds 3.
        req = 8'h08;
        tick();
        expect_out("drop0to3", 8'h08, 3'd3);

        // All requests drop. The arbiter goes idle, sel holds at 3 and y
        // is 0 even though d is all ones.
        d   = 8'hFF;
        req = 8'h00;
        tick();
        expect_out("idle_a", 8'h00, 3'd3);
        tick();
        expect_out("idle_b", 8'h00, 3'd3);
        req = 8'h40;
        tick();
        expect_out("single6", 8'h40, 3'd6);

        // Owner 6 drops its request. The search from ptr=7 wraps to 2.
        // Owner 2 then holds for 10 cycles and hcnt saturates at 4.
        req = 8'h04;
        d   = 8'h04;
        tick();
        expect_out("grant2", 8'h04, 3'd2);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold2", 32'(gnt), 32'h04);
        end
        check("hcnt_sat", 32'(dut.hcnt), 32'd4);

        // Owner 2 is saturated and 0 is waiting (ptr=3). The owner is left
        // out of the search, and the search wraps to 0.
        req = 8'h05;
        tick();
        expect_out("excl_owner", 8'h01, 3'd0);

        // Owner 0 now holds for 3 more cycles, then yields to 2 (ptr=1).
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold0", 32'(gnt), 32'h01);
        end
        tick();
        expect_out("yield0to2", 8'h04, 3'd2);

        // Owner 2 drops its request. The search from ptr=3 finds 5.
        // Owner 5 then holds with req=28.
        req = 8'h20;
        tick();
        expect_out("grant5", 8'h20, 3'd5);
        req = 8'h28;
        d   = 8'h28;
        tick();
        expect_out("hold5", 8'h20, 3'd5);

        // A one-cycle reset pulse drops the grant. Arbitration then restarts
        // from ptr=0, so 3 wins.
        rst = 1'b1;
        tick();
        expect_out("rst_mid", 8'h00, 3'd0);
        rst = 1'b0;
        tick();
        expect_out("after_rst", 8'h08, 3'd3);

        // Go idle, then pulse req[0] between two edges. The pulse must be
        // ignored because it is never sampled at a rising edge.
        req = 8'h00;
        tick();
        expect_out("idle_c", 8'h00, 3'd3);
        #2 req = 8'h01;
        #2 req = 8'h00;
        tick();
        expect_out("glitch", 8'h00, 3'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
